// File: rtl/sudoku_checker.sv
// sudoku_checker: sequential grader comparing the player board to the
// puzzle solution, one cell per clock in row-major order.
module sudoku_checker #(
    parameter int COUNT_W = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [0:8][0:8][3:0]     player_grid,
    input  logic [0:8][0:8][3:0]     solution,
    output logic                     busy,
    output logic                     done,
    output logic                     solved,
    output logic [COUNT_W-1:0]       error_count,
    output logic [COUNT_W-1:0]       empty_count,
    output logic                     first_err_valid,
    output logic [3:0]               first_err_row,
    output logic [3:0]               first_err_col,
    output logic [80:0]              err_mask
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(81);

    state_t       state;
    logic [3:0]   row;
    logic [3:0]   col;
    logic [6:0]   idx;

    logic [3:0]         cell_p;
    logic [3:0]         cell_s;
    logic               cell_empty;
    logic               cell_err;
    logic               last_cell;
    logic [COUNT_W-1:0] err_nxt;
    logic [COUNT_W-1:0] empty_nxt;

    // Classify the cell under the scan pointer and form the updated counts
    always_comb begin
        cell_p     = player_grid[row][col];
        cell_s     = solution[row][col];
        cell_empty = (cell_p == 4'd0);
        cell_err   = !cell_empty &&
                     ((cell_p > 4'd9) || (cell_p != cell_s));
        last_cell  = (row == 4'd8) && (col == 4'd8);
        err_nxt    = error_count;
        empty_nxt  = empty_count;
        if (cell_err && (error_count != MAX_CNT))
            err_nxt = error_count + 1'b1;
        if (cell_empty && (empty_count != MAX_CNT))
            empty_nxt = empty_count + 1'b1;
    end

    // Scan FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            row             <= '0;
            col             <= '0;
            idx             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            solved          <= 1'b0;
            error_count     <= '0;
            empty_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_row   <= '0;
            first_err_col   <= '0;
            err_mask        <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= SCAN;
                        busy            <= 1'b1;
                        row             <= '0;
                        col             <= '0;
                        idx             <= '0;
                        solved          <= 1'b0;
                        error_count     <= '0;
                        empty_count     <= '0;
                        first_err_valid <= 1'b0;
                        first_err_row   <= '0;
                        first_err_col   <= '0;
                        err_mask        <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    error_count <= err_nxt;
                    empty_count <= empty_nxt;
                    if (cell_err) begin
                        err_mask[idx] <= 1'b1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_row   <= row;
                            first_err_col   <= col;
                        end
                    end
                    if (last_cell) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        solved <= (err_nxt == '0) && (empty_nxt == '0);
                    end else begin
                        idx <= idx + 7'd1;
                        if (col == 4'd8) begin
                            col <= '0;
                            row <= row + 4'd1;
                        end else begin
                            col <= col + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
